debounce_multi: RTL and testbench

//  N-channel debouncer for push-buttons and switches on the MMIO subsystem.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_chan.sv | 101 ++++++++++
 rtl/debounce_multi.sv | 68 ++++++
 tb/tb_debounce_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Included by debounce_chan and debounce_multi via import debounce_pkg::*.
package debounce_pkg;

   typedef enum logic {
      CH_STABLE,
      CH_COUNTING
   } ch_state_t;

   // Counter must hold 0..STABLE_CNT-1.
   function automatic int cnt_w(input int stable_cnt);
      return $clog2(stable_cnt + 1);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-FF synchroniser, agreement counter, debounced level and edge strobes.
// Optional sticky edge flag when DEBOUNCE_EVENT_LATCH_EN is defined.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int   STABLE_CNT  = 8,
   parameter logic RESET_LEVEL = 1'b0
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic clr,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
`ifdef DEBOUNCE_EVENT_LATCH_EN
   ,
   output logic evt,
   input  logic evt_clr
`endif
);

   localparam int            CW       = cnt_w(STABLE_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

   logic [1:0]    sync_q;
   logic          sample;
   ch_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dout_d, rise_d, fall_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {2{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[0], din};
      end
   end

   assign sample = sync_q[1];

   // Any agreeing sample restarts the run, so only an unbroken run of
   // STABLE_CNT disagreeing ticks can move dout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (clr) begin
         state_d = CH_STABLE;
         cnt_d   = '0;
      end else if (tick) begin
         if (sample == dout) begin
            state_d = CH_STABLE;
            cnt_d   = '0;
         end else if (cnt_q == CNT_LAST) begin
            dout_d  = sample;
            rise_d  = sample;
            fall_d  = ~sample;
            state_d = CH_STABLE;
            cnt_d   = '0;
         end else begin
            state_d = CH_COUNTING;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= CH_STABLE;
         cnt_q   <= '0;
         dout    <= RESET_LEVEL;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout    <= dout_d;
         rise    <= rise_d;
         fall    <= fall_d;
      end
   end

`ifdef DEBOUNCE_EVENT_LATCH_EN
   // A new edge beats a clear arriving on the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         evt <= 1'b0;
      end else if (rise || fall) begin
         evt <= 1'b1;
      end else if (evt_clr) begin
         evt <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer top: shared sample-tick prescaler, en gating, and a channel array.
// Define DEBOUNCE_EVENT_LATCH_EN to add sticky evt flags with per-bit evt_clr.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int   N_CH        = 4,
   parameter int   TICK_DIV    = 100,
   parameter int   STABLE_CNT  = 8,
   parameter logic RESET_LEVEL = 1'b0
)
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            en,
   input  logic [N_CH-1:0] din,
   output logic [N_CH-1:0] dout,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall
`ifdef DEBOUNCE_EVENT_LATCH_EN
   ,
   output logic [N_CH-1:0] evt,
   input  logic [N_CH-1:0] evt_clr
`endif
);

   localparam int            PW      = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] ps_q;
   logic          tick;

   // Prescaler freezes (not clears) while en is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps_q <= '0;
      end else if (en) begin
         if (ps_q == PS_LAST) begin
            ps_q <= '0;
         end else begin
            ps_q <= ps_q + 1'b1;
         end
      end
   end

   assign tick = en && (ps_q == PS_LAST);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_chan #(
         .STABLE_CNT  (STABLE_CNT),
         .RESET_LEVEL (RESET_LEVEL)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .tick    (tick),
         .clr     (~en),
         .din     (din[i]),
         .dout    (dout[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
`ifdef DEBOUNCE_EVENT_LATCH_EN
         ,
         .evt     (evt[i]),
         .evt_clr (evt_clr[i])
`endif
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (TICK_DIV=4, STABLE_CNT=3, N_CH=4).
// Stimulus pushes expected strobes; a negedge monitor pops and checks them.
module tb_debounce_multi;

   localparam int N_CH = 4;

   typedef struct {
      int   ch;
      logic rising;
   } exp_t;

   logic            clk;
   logic            reset_n;
   logic            en;
   logic [N_CH-1:0] din;
   logic [N_CH-1:0] dout;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
`ifdef DEBOUNCE_EVENT_LATCH_EN
   logic [N_CH-1:0] evt;
   logic [N_CH-1:0] evt_clr;
`endif

   exp_t sb_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   debounce_multi #(
      .N_CH        (N_CH),
      .TICK_DIV    (4),
      .STABLE_CNT  (3),
      .RESET_LEVEL (1'b0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .din     (din),
      .dout    (dout),
      .rise    (rise),
      .fall    (fall)
`ifdef DEBOUNCE_EVENT_LATCH_EN
      ,
      .evt     (evt),
      .evt_clr (evt_clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_range(input string name, input int actual, input int lo, input int hi);
      compared++;
      if (actual < lo || actual > hi) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic applyStimulus(input int ch, input logic level, input bit expect_flip);
      exp_t e;
      din[ch] = level;
      if (expect_flip) begin
         e.ch     = ch;
         e.rising = level;
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_dout(input int ch, input logic level, input int max_cyc, output int n);
      n = 0;
      while (dout[ch] !== level && n <= max_cyc) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Every strobe must match the next expected edge, with dout already at the new level.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < N_CH; i++) begin
         if (rise[i] || fall[i]) begin
            compared++;
            if (sb_q.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpected_strobe ch%0d: rise=%0b fall=%0b, expected no strobe",
                        i, rise[i], fall[i]);
            end else begin
               e = sb_q.pop_front();
               if (e.ch != i || rise[i] != e.rising || fall[i] != !e.rising || dout[i] != e.rising) begin
                  mismatched++;
                  $display("[TB] FAIL strobe ch%0d: rise=%0b fall=%0b dout=%0b, expected ch%0d rising=%0b",
                           i, rise[i], fall[i], dout[i], e.ch, e.rising);
               end
            end
         end
      end
   end

   initial begin
      int n;
      reset_n = 1'b0;
      en      = 1'b1;
      din     = '0;
`ifdef DEBOUNCE_EVENT_LATCH_EN
      evt_clr = '0;
`endif
      repeat (3) @(negedge clk);
      checkOutput("reset_dout", int'(dout), 0);
      checkOutput("reset_strobes", int'({rise, fall}), 0);
      reset_n = 1'b1;

      repeat (100) @(negedge clk);
      checkOutput("idle_dout", int'(dout), 0);

      // Clean step on ch0
      applyStimulus(0, 1'b1, 1'b1);
      wait_dout(0, 1'b1, 30, n);
      check_range("ch0_rise_latency", n, 11, 14);
      repeat (5) @(negedge clk);

      // Short pulse on ch1 must be filtered
      applyStimulus(1, 1'b1, 1'b0);
      repeat (6) @(negedge clk);
      applyStimulus(1, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      checkOutput("ch1_pulse_filtered", int'(dout[1]), 0);

      // Bouncing ch2: latency measured from the final transition
      applyStimulus(2, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      applyStimulus(2, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      applyStimulus(2, 1'b1, 1'b1);
      wait_dout(2, 1'b1, 30, n);
      check_range("ch2_bounce_latency", n, 11, 14);
      repeat (5) @(negedge clk);

      // ch3: two disagreeing ticks, then en low clears the count
      applyStimulus(3, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      en = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("ch3_hold_en_low", int'(dout[3]), 0);
      applyStimulus(3, 1'b1, 1'b1);
      en = 1'b1;
      wait_dout(3, 1'b1, 30, n);
      check_range("ch3_fresh_count_latency", n, 9, 12);
      repeat (5) @(negedge clk);

      // Simultaneous flips on ch0 (fall) and ch1 (rise)
      applyStimulus(0, 1'b0, 1'b1);
      applyStimulus(1, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("simultaneous_dout", int'(dout), 4'b1110);

      // Async reset mid-count while dout[3]=1
      applyStimulus(3, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("pre_reset_dout3", int'(dout[3]), 1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1 checkOutput("async_reset_dout", int'(dout), 0);
      din = '0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("post_reset_dout", int'(dout), 0);

`ifdef DEBOUNCE_EVENT_LATCH_EN
      applyStimulus(0, 1'b1, 1'b1);
      wait_dout(0, 1'b1, 30, n);
      repeat (3) @(negedge clk);
      checkOutput("evt0_set", int'(evt[0]), 1);
      repeat (20) @(negedge clk);
      checkOutput("evt0_sticky", int'(evt[0]), 1);
      applyStimulus(0, 1'b0, 1'b1);
      n = 0;
      while (!fall[0] && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_range("evt0_fall_seen", n, 1, 29);
      evt_clr = 4'b0001;
      @(negedge clk);
      evt_clr = '0;
      @(negedge clk);
      checkOutput("evt0_set_beats_clear", int'(evt[0]), 1);
      evt_clr = 4'b0001;
      @(negedge clk);
      evt_clr = '0;
      @(negedge clk);
      checkOutput("evt0_lone_clear", int'(evt[0]), 0);
`endif

      repeat (20) @(negedge clk);
      checkOutput("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
